// File: rtl/axil_pkg.sv
// Shared AXI4-Lite constants: response codes and the fixed data/strobe widths.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int AXIL_DATA_W = 32;
   localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

endpackage

// File: rtl/axil_regfile_wr_join.sv
// AXI4-Lite AW/W capture and join: each channel is held independently and a
// commit strobe fires in the cycle where both address and data are available.
module axil_regfile_wr_join
   import axil_pkg::*;
#(
   parameter int AW = 7,
   parameter int DW = AXIL_DATA_W
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_en,
   input  logic [AW-1:0]   i_awaddr,
   input  logic            i_awvalid,
   input  logic [DW-1:0]   i_wdata,
   input  logic [DW/8-1:0] i_wstrb,
   input  logic            i_wvalid,
   input  logic            i_resp_pend,
   output logic            o_awready,
   output logic            o_wready,
   output logic [AW-1:0]   o_addr,
   output logic [DW-1:0]   o_data,
   output logic [DW/8-1:0] o_strb,
   output logic            o_commit,
   output logic            o_aw_held,
   output logic            o_w_held
);

   // Handshake rule: a beat transfers on a rising edge where VALID and READY are
   // both high; READY depends only on registered flags, never on VALID.
   logic            r_aw_held;
   logic            r_w_held;
   logic [AW-1:0]   r_awaddr;
   logic [DW-1:0]   r_wdata;
   logic [DW/8-1:0] r_wstrb;
   logic            w_aw_hs;
   logic            w_w_hs;

   assign o_awready = i_en && !r_aw_held && !i_resp_pend;
   assign o_wready  = i_en && !r_w_held  && !i_resp_pend;
   assign w_aw_hs   = i_awvalid && o_awready;
   assign w_w_hs    = i_wvalid  && o_wready;
   assign o_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

   // A channel arriving in the commit cycle is forwarded straight from the bus.
   assign o_addr    = r_aw_held ? r_awaddr : i_awaddr;
   assign o_data    = r_w_held  ? r_wdata  : i_wdata;
   assign o_strb    = r_w_held  ? r_wstrb  : i_wstrb;
   assign o_aw_held = r_aw_held;
   assign o_w_held  = r_w_held;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else if (o_commit) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
      end else begin
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= i_awaddr;
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= i_wdata;
            r_wstrb  <= i_wstrb;
         end
      end
   end

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite register bank with byte strobes, write pulses and registered reads.
// Define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module axil_regfile
   import axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 7,
   parameter int NUM_REGS           = 16
) (
   input  logic                                 aclk,
   input  logic                                 aresetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
   input  logic [2:0]                           S_AXI_AWPROT,
   input  logic                                 S_AXI_AWVALID,
   output logic                                 S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
   input  logic                                 S_AXI_WVALID,
   output logic                                 S_AXI_WREADY,
   output logic [1:0]                           S_AXI_BRESP,
   output logic                                 S_AXI_BVALID,
   input  logic                                 S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
   input  logic [2:0]                           S_AXI_ARPROT,
   input  logic                                 S_AXI_ARVALID,
   output logic                                 S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
   output logic [1:0]                           S_AXI_RRESP,
   output logic                                 S_AXI_RVALID,
   input  logic                                 S_AXI_RREADY,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]                  wr_pulse
);

   localparam int DW   = C_S_AXI_DATA_WIDTH;
   localparam int AW   = C_S_AXI_ADDR_WIDTH;
   localparam int IDXW = AW - 2;
`ifdef AXIL_REGFILE_SLVERR_EN
   localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
   localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

   logic [DW-1:0]   r_regs [NUM_REGS];
   logic            r_rst_done;
   logic            r_bvalid;
   logic [1:0]      r_bresp;
   logic            r_rvalid;
   logic [1:0]      r_rresp;
   logic [DW-1:0]   r_rdata;
   logic [NUM_REGS-1:0] r_wr_pulse;

   logic [AW-1:0]   w_wr_addr;
   logic [DW-1:0]   w_wr_data;
   logic [DW/8-1:0] w_wr_strb;
   logic            w_commit;
   logic            w_aw_held;
   logic            w_w_held;
   logic [NUM_REGS-1:0] w_wr_hit;
   logic [NUM_REGS-1:0] w_rd_hit;
   logic [DW-1:0]   w_rd_val;
   logic            w_ar_hs;
   logic            w_unused;

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], w_wr_addr[1:0],
                       w_aw_held, w_w_held};

   axil_regfile_wr_join #(.AW(AW), .DW(DW)) u_wr_join (
      .i_clk       (aclk),
      .i_rst_n     (aresetn),
      .i_en        (r_rst_done),
      .i_awaddr    (S_AXI_AWADDR),
      .i_awvalid   (S_AXI_AWVALID),
      .i_wdata     (S_AXI_WDATA),
      .i_wstrb     (S_AXI_WSTRB),
      .i_wvalid    (S_AXI_WVALID),
      .i_resp_pend (r_bvalid),
      .o_awready   (S_AXI_AWREADY),
      .o_wready    (S_AXI_WREADY),
      .o_addr      (w_wr_addr),
      .o_data      (w_wr_data),
      .o_strb      (w_wr_strb),
      .o_commit    (w_commit),
      .o_aw_held   (w_aw_held),
      .o_w_held    (w_w_held)
   );

   // One-hot decode; an all-zero vector means the index is out of range.
   always_comb begin
      w_wr_hit = '0;
      w_rd_hit = '0;
      w_rd_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         w_wr_hit[i] = (w_wr_addr[AW-1:2] == IDXW'(i));
         w_rd_hit[i] = (S_AXI_ARADDR[AW-1:2] == IDXW'(i));
         if (w_rd_hit[i]) w_rd_val = r_regs[i];
      end
   end

   assign w_ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

   // Keeps every READY low through reset and for the edge that follows release.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_rst_done <= 1'b0;
      else          r_rst_done <= 1'b1;
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            r_regs[g] <= '0;
         end else if (w_commit && w_wr_hit[g]) begin
            for (int b = 0; b < DW/8; b++)
               if (w_wr_strb[b]) r_regs[g][b*8 +: 8] <= w_wr_data[b*8 +: 8];
         end
      end
      assign reg_out[g*DW +: DW] = r_regs[g];
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= w_commit ? w_wr_hit : '0;
         if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= (|w_wr_hit) ? RESP_OKAY : OOR_RESP;
         end else if (S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // Read data comes from the pre-edge register value, so a same-cycle commit is not seen.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rvalid <= 1'b0;
         r_rresp  <= RESP_OKAY;
         r_rdata  <= '0;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rresp  <= (|w_rd_hit) ? RESP_OKAY : OOR_RESP;
         r_rdata  <= w_rd_val;
      end else if (S_AXI_RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

   assign S_AXI_ARREADY = r_rst_done && !r_rvalid;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RRESP   = r_rresp;
   assign S_AXI_RDATA   = r_rdata;
   assign wr_pulse      = r_wr_pulse;

endmodule

// File: tb/tb_axil_regfile.sv
// Directed bench for axil_regfile: reset, write ordering, strobes, read stall,
// out-of-range responses, read/write collision and reset mid-transaction.
module tb_axil_regfile;

   localparam int NR = 16;

   logic           aclk;
   logic           aresetn;
   logic [6:0]     S_AXI_AWADDR;
   logic [2:0]     S_AXI_AWPROT;
   logic           S_AXI_AWVALID;
   logic           S_AXI_AWREADY;
   logic [31:0]    S_AXI_WDATA;
   logic [3:0]     S_AXI_WSTRB;
   logic           S_AXI_WVALID;
   logic           S_AXI_WREADY;
   logic [1:0]     S_AXI_BRESP;
   logic           S_AXI_BVALID;
   logic           S_AXI_BREADY;
   logic [6:0]     S_AXI_ARADDR;
   logic [2:0]     S_AXI_ARPROT;
   logic           S_AXI_ARVALID;
   logic           S_AXI_ARREADY;
   logic [31:0]    S_AXI_RDATA;
   logic [1:0]     S_AXI_RRESP;
   logic           S_AXI_RVALID;
   logic           S_AXI_RREADY;
   logic [NR*32-1:0] reg_out;
   logic [NR-1:0]  wr_pulse;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_regs [NR];
   logic [1:0]  exp_oor;

   axil_regfile #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(7), .NUM_REGS(NR)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .reg_out(reg_out), .wr_pulse(wr_pulse)
   );

   // Clock and reset
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic test_reset();
      step();
      step();
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ready: got %b want 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
      end
      checks++;
      if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP} !== 6'b0 || S_AXI_RDATA !== 32'h0 || wr_pulse !== '0) begin
         errors++;
         $display("FAIL reset_outputs: bv=%b rv=%b bresp=%b rresp=%b rdata=%h pulse=%h want all 0",
                  S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, wr_pulse);
      end
      checks++;
      if (reg_out !== '0) begin
         errors++;
         $display("FAIL reset_regs: got %h want 0", reg_out);
      end
      @(negedge aclk);
      aresetn = 1'b1;
      step();
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
         errors++;
         $display("FAIL release_ready: got %b want 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
      end
   endtask

   task automatic test_same_cycle_write();
      S_AXI_AWADDR = 7'h08; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      step();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      exp_regs[2] = 32'hDEADBEEF;
      checks++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) begin
         errors++;
         $display("FAIL wr0_bvalid: bv=%b bresp=%b want 1/00", S_AXI_BVALID, S_AXI_BRESP);
      end
      checks++;
      if (reg_out[2*32 +: 32] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wr0_reg2: got %h want deadbeef", reg_out[2*32 +: 32]);
      end
      checks++;
      if (wr_pulse !== 16'h0004) begin
         errors++;
         $display("FAIL wr0_pulse: got %h want 0004", wr_pulse);
      end
      step();
      checks++;
      if (wr_pulse !== 16'h0000 || S_AXI_BVALID !== 1'b1 || S_AXI_AWREADY !== 1'b0) begin
         errors++;
         $display("FAIL wr0_hold: pulse=%h bv=%b awready=%b want 0000/1/0", wr_pulse, S_AXI_BVALID, S_AXI_AWREADY);
      end
      S_AXI_BREADY = 1'b1;
      step();
      S_AXI_BREADY = 1'b0;
      checks++;
      if (S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1 || S_AXI_WREADY !== 1'b1) begin
         errors++;
         $display("FAIL wr0_bdone: bv=%b awr=%b wr=%b want 0/1/1", S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY);
      end
   endtask

   task automatic test_w_before_aw();
      S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'h5; S_AXI_WVALID = 1'b1;
      step();
      S_AXI_WVALID = 1'b0;
      checks++;
      if (S_AXI_WREADY !== 1'b0 || S_AXI_BVALID !== 1'b0 || S_AXI_AWREADY !== 1'b1) begin
         errors++;
         $display("FAIL wfirst_held: wready=%b bv=%b awready=%b want 0/0/1", S_AXI_WREADY, S_AXI_BVALID, S_AXI_AWREADY);
      end
      step();
      step();
      S_AXI_AWADDR = 7'h04; S_AXI_AWVALID = 1'b1;
      step();
      S_AXI_AWVALID = 1'b0;
      exp_regs[1] = 32'h00340078;
      checks++;
      if (S_AXI_BVALID !== 1'b1 || reg_out[1*32 +: 32] !== 32'h00340078 || wr_pulse !== 16'h0002) begin
         errors++;
         $display("FAIL wfirst_commit: bv=%b reg1=%h pulse=%h want 1/00340078/0002",
                  S_AXI_BVALID, reg_out[1*32 +: 32], wr_pulse);
      end
      S_AXI_BREADY = 1'b1;
      step();
      S_AXI_BREADY = 1'b0;
   endtask

   task automatic test_read_stall();
      S_AXI_ARADDR = 7'h08; S_AXI_ARVALID = 1'b1;
      step();
      S_AXI_ARVALID = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hDEADBEEF || S_AXI_RRESP !== 2'b00 || S_AXI_ARREADY !== 1'b0) begin
            errors++;
            $display("FAIL rd_stall[%0d]: rv=%b rdata=%h rresp=%b arready=%b want 1/deadbeef/00/0",
                     k, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY);
         end
         if (k < 3) step();
      end
      S_AXI_RREADY = 1'b1;
      step();
      S_AXI_RREADY = 1'b0;
      checks++;
      if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
         errors++;
         $display("FAIL rd_done: rv=%b arready=%b want 0/1", S_AXI_RVALID, S_AXI_ARREADY);
      end
   endtask

   task automatic test_out_of_range();
      S_AXI_AWADDR = 7'h7C; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'hFFFFFFFF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      step();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      checks++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== exp_oor || wr_pulse !== '0) begin
         errors++;
         $display("FAIL oor_write: bv=%b bresp=%b pulse=%h want 1/%b/0000", S_AXI_BVALID, S_AXI_BRESP, wr_pulse, exp_oor);
      end
      for (int i = 0; i < NR; i++) begin
         checks++;
         if (reg_out[i*32 +: 32] !== exp_regs[i]) begin
            errors++;
            $display("FAIL oor_reg[%0d]: got %h want %h", i, reg_out[i*32 +: 32], exp_regs[i]);
         end
      end
      S_AXI_BREADY = 1'b1;
      S_AXI_ARADDR = 7'h7C; S_AXI_ARVALID = 1'b1;
      step();
      S_AXI_BREADY = 1'b0; S_AXI_ARVALID = 1'b0;
      checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h0 || S_AXI_RRESP !== exp_oor) begin
         errors++;
         $display("FAIL oor_read: rv=%b rdata=%h rresp=%b want 1/0/%b", S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, exp_oor);
      end
      S_AXI_RREADY = 1'b1;
      step();
      S_AXI_RREADY = 1'b0;
   endtask

   task automatic test_read_write_collision();
      S_AXI_AWADDR = 7'h0C; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      step();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b1;
      step();
      S_AXI_BREADY = 1'b0;
      S_AXI_AWADDR = 7'h0C; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h2; S_AXI_WVALID = 1'b1;
      S_AXI_ARADDR = 7'h0C; S_AXI_ARVALID = 1'b1;
      step();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      exp_regs[3] = 32'h2;
      checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h1) begin
         errors++;
         $display("FAIL collide_old: rv=%b rdata=%h want 1/00000001", S_AXI_RVALID, S_AXI_RDATA);
      end
      checks++;
      if (S_AXI_BVALID !== 1'b1 || reg_out[3*32 +: 32] !== 32'h2) begin
         errors++;
         $display("FAIL collide_wr: bv=%b reg3=%h want 1/00000002", S_AXI_BVALID, reg_out[3*32 +: 32]);
      end
      S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
      step();
      S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
      S_AXI_ARADDR = 7'h0C; S_AXI_ARVALID = 1'b1;
      step();
      S_AXI_ARVALID = 1'b0;
      checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h2) begin
         errors++;
         $display("FAIL collide_new: rv=%b rdata=%h want 1/00000002", S_AXI_RVALID, S_AXI_RDATA);
      end
      S_AXI_RREADY = 1'b1;
      step();
      S_AXI_RREADY = 1'b0;
   endtask

   task automatic test_reset_mid();
      S_AXI_AWADDR = 7'h14; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'hA5A5A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      step();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      checks++;
      if (S_AXI_BVALID !== 1'b1 || reg_out[5*32 +: 32] !== 32'hA5A5A5A5) begin
         errors++;
         $display("FAIL mid_pre: bv=%b reg5=%h want 1/a5a5a5a5", S_AXI_BVALID, reg_out[5*32 +: 32]);
      end
      #2;
      aresetn = 1'b0;
      #1;
      for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
      checks++;
      if (S_AXI_BVALID !== 1'b0 || reg_out !== '0 || S_AXI_AWREADY !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: bv=%b regs_nonzero=%b awready=%b want 0/0/0", S_AXI_BVALID, |reg_out, S_AXI_AWREADY);
      end
      step();
      @(negedge aclk);
      aresetn = 1'b1;
      step();
      checks++;
      if (S_AXI_AWREADY !== 1'b1 || S_AXI_BVALID !== 1'b0) begin
         errors++;
         $display("FAIL mid_release: awready=%b bv=%b want 1/0", S_AXI_AWREADY, S_AXI_BVALID);
      end
      S_AXI_AWADDR = 7'h14; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h00000011; S_AXI_WSTRB = 4'h1; S_AXI_WVALID = 1'b1;
      step();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      exp_regs[5] = 32'h00000011;
      checks++;
      if (S_AXI_BVALID !== 1'b1 || reg_out[5*32 +: 32] !== exp_regs[5] || wr_pulse !== 16'h0020) begin
         errors++;
         $display("FAIL mid_after: bv=%b reg5=%h pulse=%h want 1/00000011/0020", S_AXI_BVALID, reg_out[5*32 +: 32], wr_pulse);
      end
      S_AXI_BREADY = 1'b1;
      step();
      S_AXI_BREADY = 1'b0;
   endtask

   initial begin
`ifdef AXIL_REGFILE_SLVERR_EN
      exp_oor = 2'b10;
`else
      exp_oor = 2'b00;
`endif
      for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
      aresetn = 1'b0;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY = 1'b0;

      test_reset();
      test_same_cycle_write();
      test_w_before_aw();
      test_read_stall();
      test_out_of_range();
      test_read_write_collision();
      test_reset_mid();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
